// File: rtl/apb_master_bridge_if.sv
// Command/response streams plus requester-side APB signals of apb_master_bridge.
// The master modport is the bridge's view; slave is the agent/completer view.
interface apb_master_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_write;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSELx;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready, PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready, PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: command stream -> SETUP/ACCESS -> response stream.
// Optional ACCESS wait limit enabled by defining APB_MASTER_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  timeout;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

  // Hitting the limit with PREADY=1 still completes normally.
  assign timeout = (state_q == StAccess) && !bus.PREADY &&
                   (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StIdle && bus.cmd_valid) begin
      wait_cnt_d = '0;
    end else if (state_q == StAccess && !bus.PREADY) begin
      wait_cnt_d = wait_cnt_q + WaitW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pwdata_d    = bus.cmd_wdata;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        if (bus.PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = StResp;
        end else if (timeout) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSELx     = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed, table-driven bench for apb_master_bridge; the completer is modelled inline.
// Covers timeout behaviour for both settings of APB_MASTER_BRIDGE_TIMEOUT_EN.
module tb_apb_master_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  logic PCLK;
  logic PRESET;

  apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_master_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [7:0]  hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [4];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int n_en;
    @(negedge PCLK);
    check($sformatf("v%0d cmd_ready idle", k), bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = v.addr;
    bus.cmd_write = v.write;
    bus.cmd_wdata = v.wdata;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'hFFFF_FFF0;
    bus.cmd_wdata = 32'h0BAD_F00D;
    @(negedge PCLK);
    check($sformatf("v%0d setup psel", k), bus.PSELx, 1);
    check($sformatf("v%0d setup penable", k), bus.PENABLE, 0);
    check($sformatf("v%0d setup paddr", k), bus.PADDR, v.addr);
    check($sformatf("v%0d setup pwrite", k), bus.PWRITE, v.write);
    if (v.write) check($sformatf("v%0d setup pwdata", k), bus.PWDATA, v.wdata);
    check($sformatf("v%0d setup cmd_ready", k), bus.cmd_ready, 0);
    tick();
    n_en = 0;
    for (int i = 0; i <= int'(v.waits); i++) begin
      @(negedge PCLK);
      if (bus.PENABLE && bus.PSELx) n_en++;
      check($sformatf("v%0d access%0d paddr", k, i), bus.PADDR, v.addr);
      if (v.write) check($sformatf("v%0d access%0d pwdata", k, i), bus.PWDATA, v.wdata);
      check($sformatf("v%0d access%0d rsp_valid", k, i), bus.rsp_valid, 0);
      bus.PREADY  = (i == int'(v.waits));
      bus.PRDATA  = bus.PREADY ? v.prdata : (32'hBAD0_0000 | 32'(i));
      bus.PSLVERR = bus.PREADY ? v.slverr : ~v.slverr;
      tick();
    end
    bus.PREADY  = 1'b0;
    bus.PRDATA  = 32'hFFFF_FFFF;
    bus.PSLVERR = 1'b1;
    check($sformatf("v%0d penable cycles", k), n_en, int'(v.waits) + 1);
    for (int h = 0; h <= int'(v.hold); h++) begin
      @(negedge PCLK);
      check($sformatf("v%0d resp%0d rsp_valid", k, h), bus.rsp_valid, 1);
      check($sformatf("v%0d resp%0d rsp_rdata", k, h), bus.rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d resp%0d rsp_err", k, h), bus.rsp_err, v.exp_err);
      check($sformatf("v%0d resp%0d psel", k, h), {bus.PSELx, bus.PENABLE}, 2'b00);
      check($sformatf("v%0d resp%0d cmd_ready", k, h), bus.cmd_ready, 0);
      if (h == int'(v.hold)) bus.rsp_ready = 1'b1;
    end
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge PCLK);
    check($sformatf("v%0d after rsp_valid", k), bus.rsp_valid, 0);
    check($sformatf("v%0d after cmd_ready", k), bus.cmd_ready, 1);
  endtask

  task automatic issue_read(input logic [31:0] addr);
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] bb_data [3];
    int          rise    [3];
    int          nr, nrsp, idx, n_en, bad;
    logic        prev_psel, hs;

    vecs[0] = '{write: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF, waits: 8'd0,
                prdata: 32'h55AA_55AA, slverr: 1'b0, hold: 8'd0,
                exp_rdata: 32'h0, exp_err: 1'b0};
    vecs[1] = '{write: 1'b0, addr: 32'h24, wdata: 32'h0, waits: 8'd3,
                prdata: 32'h1234_5678, slverr: 1'b0, hold: 8'd1,
                exp_rdata: 32'h1234_5678, exp_err: 1'b0};
    vecs[2] = '{write: 1'b0, addr: 32'h30, wdata: 32'h0, waits: 8'd0,
                prdata: 32'hCAFE_F00D, slverr: 1'b1, hold: 8'd5,
                exp_rdata: 32'hCAFE_F00D, exp_err: 1'b1};
    vecs[3] = '{write: 1'b1, addr: 32'h3C, wdata: 32'hA5A5_0F0F, waits: 8'd2,
                prdata: 32'h9999_9999, slverr: 1'b1, hold: 8'd0,
                exp_rdata: 32'h0, exp_err: 1'b1};

    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;
    tick();
    tick();
    @(negedge PCLK);
    check("reset cmd_ready", bus.cmd_ready, 1);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset rsp_rdata", bus.rsp_rdata, 0);
    check("reset rsp_err", bus.rsp_err, 0);
    check("reset psel/penable", {bus.PSELx, bus.PENABLE}, 2'b00);
    check("reset paddr", bus.PADDR, 0);
    check("reset pwrite", bus.PWRITE, 0);
    check("reset pwdata", bus.PWDATA, 0);
    PRESET = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) run_vec(vecs[k], k);

    // Reset during an ACCESS wait: transfer is dropped.
    issue_read(32'h44);
    tick();
    tick();
    @(negedge PCLK);
    check("midreset pre penable", bus.PENABLE, 1);
    PRESET = 1'b1;
    tick();
    PRESET     = 1'b0;
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h7777_7777;
    @(negedge PCLK);
    check("midreset psel/penable", {bus.PSELx, bus.PENABLE}, 2'b00);
    check("midreset cmd_ready", bus.cmd_ready, 1);
    check("midreset paddr", bus.PADDR, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid || bus.PSELx) bad++;
    end
    check("midreset no response", bad, 0);
    bus.PREADY = 1'b0;

    // PREADY held low forever.
    issue_read(32'h50);
    bus.PRDATA  = 32'hDEAD_0001;
    bus.PSLVERR = 1'b0;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    n_en = 0;
    begin
      int c;
      for (c = 0; c < 30; c++) begin
        @(negedge PCLK);
        if (bus.rsp_valid) break;
        if (bus.PENABLE) n_en++;
      end
      check("timeout bound reached", c < 30, 1);
    end
    check("timeout access cycles", n_en, TO);
    check("timeout rsp_err", bus.rsp_err, 1);
    check("timeout rsp_rdata", bus.rsp_rdata, 0);
    check("timeout psel/penable", {bus.PSELx, bus.PENABLE}, 2'b00);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge PCLK);
    check("timeout cmd_ready after", bus.cmd_ready, 1);
`else
    tick();
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge PCLK);
      if (!bus.PENABLE || !bus.PSELx || bus.rsp_valid) bad++;
    end
    check("no-timeout access held", bad, 0);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
`endif

    // Back-to-back zero-wait writes.
    bb_data[0]    = 32'h1111_0001;
    bb_data[1]    = 32'h2222_0002;
    bb_data[2]    = 32'h3333_0003;
    nr            = 0;
    nrsp          = 0;
    idx           = 0;
    prev_psel     = 1'b0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h80;
    bus.cmd_wdata = bb_data[0];
    bus.cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge PCLK);
      if (bus.PSELx && !prev_psel && nr < 3) begin
        rise[nr] = cyc;
        check($sformatf("b2b setup%0d pwdata", nr), bus.PWDATA, bb_data[nr]);
        nr++;
      end
      prev_psel = bus.PSELx;
      if (bus.rsp_valid) begin
        check($sformatf("b2b rsp%0d err", nrsp), bus.rsp_err, 0);
        nrsp++;
      end
      hs = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (hs) begin
        idx++;
        if (idx == 3) bus.cmd_valid = 1'b0;
        else bus.cmd_wdata = bb_data[idx];
      end
    end
    check("b2b transfers", nr, 3);
    check("b2b responses", nrsp, 3);
    if (nr == 3) begin
      check("b2b gap 0-1", rise[1] - rise[0], 4);
      check("b2b gap 1-2", rise[2] - rise[1], 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB requester that turns a valid/ready command stream into APB SETUP/ACCESS transfers and returns each result on a valid/ready response stream. It sits upstream of the APB demux and drives the same APB signal set into the demux's requester-side port, so on-chip agents (CPU shim, DMA, test sequencer) can issue register accesses without knowing APB phase rules.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
- ADDR_WIDTH, 32, width of PADDR/cmd_addr
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit, ≥1; used only with the timeout feature

Ports (one clock; reset is synchronous and active-high):
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid&cmd_ready
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_write  in  1  1=write, 0=read
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR captured, or timeout
- PSELx  out  1  APB select
- PENABLE  out  1  APB access phase
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PREADY  in  1  completer ready
- PRDATA  in  DATA_WIDTH  completer read data
- PSLVERR  in  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, register cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA → SETUP.
- SETUP: PSELx=1, PENABLE=0, cmd_ready=0 → ACCESS unconditionally.
- ACCESS: PSELx=1, PENABLE=1. PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR → RESP. PREADY=0: stay (wait states unlimited unless timeout feature compiled in).
- PRDATA/PSLVERR sampled only in the ACCESS cycle with PREADY=1; ignored otherwise.
- RESP: PSELx=0, PENABLE=0, rsp_valid=1; rsp_rdata/rsp_err held stable. On rsp_ready → IDLE. cmd_ready stays 0 in RESP (one outstanding transfer).
- PADDR/PWRITE/PWDATA stable from SETUP through the end of ACCESS; they hold their last value in RESP/IDLE.
- PRESET (any state, including mid-ACCESS): next edge → IDLE, all outputs 0 except cmd_ready=1; in-flight transfer dropped, no response produced.
- Reset values: cmd_ready=1; rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PADDR, PWRITE, PWDATA all 0.

## Timing
- All outputs registered.
- Command handshake at edge N → SETUP visible cycle N+1 → ACCESS cycle N+2.
- Zero-wait completer (PREADY=1 at N+2): rsp_valid=1 in cycle N+3. Each wait state adds 1 cycle.
- rsp_ready held high: next cmd_ready=1 at N+4. Peak throughput = 1 transfer per 4 cycles.
- PENABLE never 1 without PSELx; PSELx→PENABLE always exactly one SETUP cycle apart.

## Configuration
- APB_MASTER_BRIDGE_TIMEOUT_EN defined: wait counter clears on SETUP entry and increments in each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES (PREADY still 0), transfer is abandoned → RESP with rsp_err=1, rsp_rdata=0; PSELx/PENABLE drop. PREADY=1 in the same cycle the limit is hit counts as normal completion.
- Not defined: no counter logic, ACCESS waits indefinitely, TIMEOUT_CYCLES unused.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, PREADY tied 1 → SETUP N+1, ACCESS N+2 with PWDATA=0xDEADBEEF, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read addr 0x24, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678 → PENABLE high 4 cycles, rsp_rdata=0x12345678 at N+6; PADDR constant throughout.
- Read with PSLVERR=1 on completion, rsp_ready held low 5 cycles → rsp_err=1, rsp_valid and data stable 5 cycles, cmd_ready=0 until handshake.
- PRESET asserted during ACCESS wait → next cycle PSELx=PENABLE=0, cmd_ready=1, rsp_valid never asserts for that command.
- With APB_MASTER_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 → ACCESS lasts 4 cycles, then rsp_err=1, rsp_rdata=0; without the macro, same stimulus keeps ACCESS for 100+ cycles with no response.
- Back-to-back: cmd_valid and rsp_ready held 1, 3 writes to zero-wait completer → PSELx rising edges 4 cycles apart, responses in order.
